// File: rtl/rotate_seq_ctrl_if.sv
// Handshake/strobe bundle between the rotate sequencer (master) and its consumers (slave).
// The abort/aborted pair exists only when ROTATE_SEQ_ABORT_EN is defined.
interface rotate_seq_ctrl_if #(
  parameter int LANES = 24,
  parameter int BITS  = 64
);
  logic                     start;
  logic                     busy;
  logic                     read_en;
  logic                     wr_en;
  logic                     file_write;
  logic                     done;
  logic [$clog2(LANES)-1:0] lane_idx;
  logic [$clog2(BITS)-1:0]  bit_idx;
`ifdef ROTATE_SEQ_ABORT_EN
  logic                     abort;
  logic                     aborted;

  modport master (
    input  start, abort,
    output busy, read_en, wr_en, file_write, done, lane_idx, bit_idx, aborted
  );
  modport slave (
    output start, abort,
    input  busy, read_en, wr_en, file_write, done, lane_idx, bit_idx, aborted
  );
`else
  modport master (
    input  start,
    output busy, read_en, wr_en, file_write, done, lane_idx, bit_idx
  );
  modport slave (
    output start,
    input  busy, read_en, wr_en, file_write, done, lane_idx, bit_idx
  );
`endif
endinterface

// File: rtl/rotate_seq_ctrl.sv
// Rotate-step sequencer: owns lane/bit/latency counters and emits registered Moore strobes.
// Optional abort path is compiled in with ROTATE_SEQ_ABORT_EN.
module rotate_seq_ctrl #(
  parameter int LANES  = 24,
  parameter int BITS   = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  rotate_seq_ctrl_if.master bus
);
  localparam int LW       = $clog2(LANES);
  localparam int BW       = $clog2(BITS);
  localparam int LAT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_WRITE, S_NEXT, S_FLUSH, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [1:0]    lat_q, lat_d;
  logic          busy_q, read_en_q, wr_en_q, file_write_q, done_q;
  logic          abort_hit;

`ifdef ROTATE_SEQ_ABORT_EN
  logic          aborted_q;
  assign abort_hit = bus.abort && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    bit_d   = bit_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        lane_d = '0;
        bit_d  = '0;
        lat_d  = '0;
        if (bus.start) state_d = S_READ;
      end
      S_READ: begin
        lane_d  = '0;
        lat_d   = '0;
        state_d = (RD_LAT > 1) ? S_WAIT : S_WRITE;
      end
      S_WAIT: begin
        if (int'(lat_q) == LAT_LAST) state_d = S_WRITE;
        else                         lat_d   = lat_q + 2'd1;
      end
      S_WRITE: begin
        // Explicit wrap keeps non-power-of-two lane counts correct.
        if (lane_q == LANE_LAST) begin
          lane_d  = '0;
          state_d = S_NEXT;
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end
      S_NEXT: begin
        lane_d = '0;
        if (bit_q == BIT_LAST) begin
          state_d = S_FLUSH;
        end else begin
          bit_d   = bit_q + BW'(1);
          state_d = S_READ;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        bit_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      state_d = S_IDLE;
      lane_d  = '0;
      bit_d   = '0;
      lat_d   = '0;
    end
  end

  // Strobes are decoded from the next state so they line up with state_q after the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      bit_q        <= '0;
      lat_q        <= '0;
      busy_q       <= 1'b0;
      read_en_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      file_write_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef ROTATE_SEQ_ABORT_EN
      aborted_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      bit_q        <= bit_d;
      lat_q        <= lat_d;
      busy_q       <= (state_d != S_IDLE);
      read_en_q    <= (state_d == S_READ);
      wr_en_q      <= (state_d == S_WRITE);
      file_write_q <= (state_d == S_FLUSH);
      done_q       <= (state_d == S_DONE);
`ifdef ROTATE_SEQ_ABORT_EN
      aborted_q    <= abort_hit;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.read_en    = read_en_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.file_write = file_write_q;
  assign bus.done       = done_q;
  assign bus.lane_idx   = lane_q;
  assign bus.bit_idx    = bit_q;
`ifdef ROTATE_SEQ_ABORT_EN
  assign bus.aborted    = aborted_q;
`endif

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Bench for rotate_seq_ctrl: default-size and small (5 lanes, 3 bits, latency 3) instances
// checked against a schedule-arithmetic model, a vector table and directed sequences.
module tb_rotate_seq_ctrl;
  localparam int BL = 24, BB = 64, BR = 1;
  localparam int SL = 5,  SB = 3,  SR = 3;
  localparam int B_END = BB * (BR + BL + 1) + 2;
  localparam int S_END = SB * (SR + SL + 1) + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic abort_b = 1'b0;
  logic abort_s = 1'b0;
  always #5 clk = ~clk;

  rotate_seq_ctrl_if #(.LANES(BL), .BITS(BB)) bif ();
  rotate_seq_ctrl_if #(.LANES(SL), .BITS(SB)) sif ();

`ifdef ROTATE_SEQ_ABORT_EN
  assign bif.abort = abort_b;
  assign sif.abort = abort_s;
`endif

  rotate_seq_ctrl #(.LANES(BL), .BITS(BB), .RD_LAT(BR)) u_big (.clk(clk), .rst(rst), .bus(bif.master));
  rotate_seq_ctrl #(.LANES(SL), .BITS(SB), .RD_LAT(SR)) u_sml (.clk(clk), .rst(rst), .bus(sif.master));

  typedef struct packed {
    logic        busy;
    logic        read_en;
    logic        wr_en;
    logic        fw;
    logic        done;
    logic        aborted;
    logic [15:0] lane;
    logic [15:0] bitn;
  } outs_t;

  typedef struct {
    int    cyc;
    outs_t e;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int r_b = 0, r_s = 0;
  bit abf_b = 1'b0, abf_s = 1'b0;

  // Expected outputs at position r of a run (r=0 idle, r=1 the READ of bit 0).
  function automatic outs_t model_out(int r, int L, int B, int RL, bit ab);
    outs_t o;
    int p, k, total;
    o = '0;
    p = RL + L + 1;
    total = B * p;
    o.aborted = ab;
    if (r >= 1 && r <= total) begin
      o.busy = 1'b1;
      o.bitn = 16'((r - 1) / p);
      k = (r - 1) % p;
      if (k == 0) o.read_en = 1'b1;
      else if (k >= RL && k < RL + L) begin
        o.wr_en = 1'b1;
        o.lane  = 16'(k - RL);
      end
    end else if (r == total + 1) begin
      o.busy = 1'b1; o.fw = 1'b1; o.bitn = 16'(B - 1);
    end else if (r == total + 2) begin
      o.busy = 1'b1; o.done = 1'b1; o.bitn = 16'(B - 1);
    end
    return o;
  endfunction

  function automatic int next_r(int r, bit rstn, bit st, bit ab, int last);
    if (!rstn) return 0;
    if (r != 0 && ab) return 0;
    if (r == 0) return st ? 1 : 0;
    if (r == last) return 0;
    return r + 1;
  endfunction

  function automatic outs_t mk(bit bz, bit rd, bit wr, bit fw, bit dn, int lane, int bitn);
    outs_t o;
    o = '0;
    o.busy = bz; o.read_en = rd; o.wr_en = wr; o.fw = fw; o.done = dn;
    o.lane = 16'(lane); o.bitn = 16'(bitn);
    return o;
  endfunction

  function automatic outs_t act_big();
    outs_t o;
    o.busy = bif.busy; o.read_en = bif.read_en; o.wr_en = bif.wr_en;
    o.fw = bif.file_write; o.done = bif.done;
    o.lane = 16'(bif.lane_idx); o.bitn = 16'(bif.bit_idx);
`ifdef ROTATE_SEQ_ABORT_EN
    o.aborted = bif.aborted;
`else
    o.aborted = 1'b0;
`endif
    return o;
  endfunction

  function automatic outs_t act_sml();
    outs_t o;
    o.busy = sif.busy; o.read_en = sif.read_en; o.wr_en = sif.wr_en;
    o.fw = sif.file_write; o.done = sif.done;
    o.lane = 16'(sif.lane_idx); o.bitn = 16'(sif.bit_idx);
`ifdef ROTATE_SEQ_ABORT_EN
    o.aborted = sif.aborted;
`else
    o.aborted = 1'b0;
`endif
    return o;
  endfunction

  task automatic chk_outs(string nm, outs_t a, outs_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, a, e);
    end
  endtask

  task automatic chk_int(string nm, int a, int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // One clock: advance the reference with the inputs seen at the edge, then compare both instances.
  task automatic tick();
    @(posedge clk);
    abf_b = rst && (r_b != 0) && abort_b;
    abf_s = rst && (r_s != 0) && abort_s;
    r_b = next_r(r_b, rst, bif.start, abort_b, B_END);
    r_s = next_r(r_s, rst, sif.start, abort_s, S_END);
    #1;
    chk_outs("model_big", act_big(), model_out(r_b, BL, BB, BR, abf_b));
    chk_outs("model_sml", act_sml(), model_out(r_s, SL, SB, SR, abf_s));
  endtask

  vec_t tbl[16];
  int   cyc, d, n_rd, n_wr, n_fw, n_dn, fw_cyc, dn_cyc;

  initial begin
    bif.start = 1'b0;
    sif.start = 1'b0;

    // Reset state
    repeat (3) tick();
    chk_outs("reset_big", act_big(), '0);
    chk_outs("reset_sml", act_sml(), '0);
    rst = 1'b1;
    tick();

    // Small instance against hand-derived vectors
    tbl[0]  = '{1,  mk(1, 1, 0, 0, 0, 0, 0)};
    tbl[1]  = '{2,  mk(1, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{3,  mk(1, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{4,  mk(1, 0, 1, 0, 0, 0, 0)};
    tbl[4]  = '{6,  mk(1, 0, 1, 0, 0, 2, 0)};
    tbl[5]  = '{8,  mk(1, 0, 1, 0, 0, 4, 0)};
    tbl[6]  = '{9,  mk(1, 0, 0, 0, 0, 0, 0)};
    tbl[7]  = '{10, mk(1, 1, 0, 0, 0, 0, 1)};
    tbl[8]  = '{13, mk(1, 0, 1, 0, 0, 0, 1)};
    tbl[9]  = '{17, mk(1, 0, 1, 0, 0, 4, 1)};
    tbl[10] = '{19, mk(1, 1, 0, 0, 0, 0, 2)};
    tbl[11] = '{26, mk(1, 0, 1, 0, 0, 4, 2)};
    tbl[12] = '{27, mk(1, 0, 0, 0, 0, 0, 2)};
    tbl[13] = '{28, mk(1, 0, 0, 1, 0, 0, 2)};
    tbl[14] = '{29, mk(1, 0, 0, 0, 1, 0, 2)};
    tbl[15] = '{30, mk(0, 0, 0, 0, 0, 0, 0)};
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    cyc = 1;
    for (int i = 0; i < 16; i++) begin
      while (cyc < tbl[i].cyc) begin
        tick();
        cyc++;
      end
      chk_outs($sformatf("tbl_cyc%0d", tbl[i].cyc), act_sml(), tbl[i].e);
    end

    // Default full run with an ignored second start at cycle 100
    n_rd = 0; n_wr = 0; n_fw = 0; n_dn = 0; fw_cyc = -1; dn_cyc = -1;
    bif.start = 1'b1;
    tick();
    for (int c = 1; c <= 1670; c++) begin
      if (bif.read_en) n_rd++;
      if (bif.wr_en) n_wr++;
      if (bif.file_write) begin n_fw++; fw_cyc = c; end
      if (bif.done) begin n_dn++; dn_cyc = c; end
      bif.start = (c == 100);
      tick();
    end
    chk_int("full_read_en_count", n_rd, 64);
    chk_int("full_wr_en_count", n_wr, 1536);
    chk_int("full_file_write_cycle", fw_cyc, 1665);
    chk_int("full_done_cycle", dn_cyc, 1666);
    chk_int("full_file_write_count", n_fw, 1);
    chk_int("full_done_count", n_dn, 1);

    // start held high: done, one IDLE cycle, then a fresh READ
    bif.start = 1'b1;
    tick();
    d = -1;
    for (int c = 1; c <= 2000; c++) begin
      if (bif.done) begin
        d = c;
        break;
      end
      tick();
    end
    chk_int("held_done_cycle", d, 1666);
    tick();
    chk_int("held_idle_gap_busy", int'(bif.busy), 0);
    tick();
    chk_int("held_restart_read_en", int'(bif.read_en), 1);
    chk_int("held_restart_bit_idx", int'(bif.bit_idx), 0);
    bif.start = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // Reset during WRITE at bit 10, lane 7
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    repeat (268) tick();
    chk_int("pre_rst_wr_en", int'(bif.wr_en), 1);
    chk_int("pre_rst_lane", int'(bif.lane_idx), 7);
    chk_int("pre_rst_bit", int'(bif.bit_idx), 10);
    rst = 1'b0;
    tick();
    chk_outs("mid_rst_outputs", act_big(), '0);
    rst = 1'b1;
    n_fw = 0; n_dn = 0;
    for (int c = 0; c < 1700; c++) begin
      tick();
      if (bif.file_write) n_fw++;
      if (bif.done) n_dn++;
    end
    chk_int("post_rst_file_write", n_fw, 0);
    chk_int("post_rst_done", n_dn, 0);

`ifdef ROTATE_SEQ_ABORT_EN
    // Abort during WRITE
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (4) tick();
    chk_int("pre_abort_wr_en", int'(sif.wr_en), 1);
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    chk_int("abort_write_aborted", int'(sif.aborted), 1);
    chk_int("abort_write_busy", int'(sif.busy), 0);
    tick();
    chk_int("abort_write_aborted_clear", int'(sif.aborted), 0);
    n_dn = 0;
    repeat (40) begin tick(); if (sif.done) n_dn++; end
    chk_int("abort_write_no_done", n_dn, 0);

    // Abort during FLUSH
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (27) tick();
    chk_int("pre_abort_flush_fw", int'(sif.file_write), 1);
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    chk_int("abort_flush_aborted", int'(sif.aborted), 1);
    n_fw = 0; n_dn = 0;
    repeat (40) begin tick(); if (sif.file_write) n_fw++; if (sif.done) n_dn++; end
    chk_int("abort_flush_no_fw", n_fw, 0);
    chk_int("abort_flush_no_done", n_dn, 0);
`endif

    // Randomized start/reset traffic, compared every cycle against the model
    for (int c = 0; c < 2500; c++) begin
      sif.start = ($urandom_range(0, 7) == 0);
      bif.start = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 199) != 0);
`ifdef ROTATE_SEQ_ABORT_EN
      abort_s = ($urandom_range(0, 39) == 0);
      abort_b = ($urandom_range(0, 39) == 0);
`endif
      tick();
    end
    sif.start = 1'b0;
    bif.start = 1'b0;
    abort_s = 1'b0;
    abort_b = 1'b0;
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
